// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine sequencing controller.
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VEND,
    S_CHANGE
  } vend_state_e;

  localparam int unsigned NPROD          = 4;
  localparam int unsigned CREDIT_W_DEF   = 5;
  localparam int unsigned STOCK_W_DEF    = 4;
  localparam int unsigned INIT_STOCK_DEF = 3;

  localparam int unsigned PRICE [NPROD] = '{2, 3, 5, 7};

endpackage

// File: rtl/vend_stock_bank.sv
// Per-product stock counters with single-index decrement and global restock.
module vend_stock_bank
  import vend_pkg::*;
#(
  parameter  int unsigned STOCK_W    = STOCK_W_DEF,
  parameter  int unsigned INIT_STOCK = INIT_STOCK_DEF,
  localparam int unsigned SEL_W      = $clog2(NPROD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_en,
  input  logic [SEL_W-1:0] dec_idx,
  input  logic             restock,
  output logic [NPROD-1:0] empty
);

  logic [STOCK_W-1:0] stock [NPROD];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NPROD; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else if (restock) begin
      for (int unsigned i = 0; i < NPROD; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else if (dec_en && stock[dec_idx] != '0) begin
      stock[dec_idx] <= stock[dec_idx] - STOCK_W'(1);
    end
  end

  always_comb begin
    empty = '0;
    for (int unsigned i = 0; i < NPROD; i++) empty[i] = (stock[i] == '0);
  end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, selection checks, dispense handshake, change payout.
module vend_controller
  import vend_pkg::*;
#(
  parameter  int unsigned CREDIT_W   = CREDIT_W_DEF,
  parameter  int unsigned STOCK_W    = STOCK_W_DEF,
  parameter  int unsigned INIT_STOCK = INIT_STOCK_DEF,
  localparam int unsigned SEL_W      = $clog2(NPROD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [2:0]          coin_val,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  input  logic                restock,
  output logic                vend_req,
  output logic [SEL_W-1:0]    vend_id,
  input  logic                vend_done,
  output logic                chg_valid,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_rej,
  output logic                err_funds,
  output logic                err_sold_out
);

  localparam int unsigned   W1   = CREDIT_W + 1;
  localparam logic [W1-1:0] MAXC = {1'b0, {CREDIT_W{1'b1}}};

  vend_state_e         state, state_d;
  logic [CREDIT_W-1:0] credit_d;
  logic [SEL_W-1:0]    vend_id_d;
  logic                coin_rej_d, err_funds_d, err_sold_d;
  logic                dec_en, restock_en, coin_nz;
  logic [W1-1:0]       cr, cv, price, sum;
  logic [NPROD-1:0]    empty;

  assign coin_nz = coin_valid && (coin_val != '0);
  assign cr      = W1'(credit);
  assign cv      = W1'(coin_val);
  assign price   = W1'(PRICE[sel]);

  vend_stock_bank #(
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK)
  ) u_stock (
    .clk     (clk),
    .rst     (rst),
    .dec_en  (dec_en),
    .dec_idx (sel),
    .restock (restock_en),
    .empty   (empty)
  );

  always_comb begin
    state_d     = state;
    credit_d    = credit;
    vend_id_d   = vend_id;
    coin_rej_d  = 1'b0;
    err_funds_d = 1'b0;
    err_sold_d  = 1'b0;
    dec_en      = 1'b0;
    restock_en  = 1'b0;
    sum         = cr;
    case (state)
      S_IDLE: begin
        // Coin acceptance is independent of the cancel/select decision below
        if (coin_nz) begin
          if (cr + cv <= MAXC) sum = cr + cv;
          else                 coin_rej_d = 1'b1;
        end
        if (cancel) begin
          if (cr != '0) state_d = S_CHANGE;
        end else if (sel_valid) begin
          if (empty[sel]) begin
            err_sold_d = 1'b1;
          end else if (cr < price) begin
            err_funds_d = 1'b1;
          end else begin
            dec_en    = 1'b1;
            sum       = sum - price;
            vend_id_d = sel;
            state_d   = S_VEND;
          end
        end else if (restock) begin
          restock_en = 1'b1;
        end
        credit_d = CREDIT_W'(sum);
      end
      S_VEND: begin
        coin_rej_d = coin_nz;
        if (vend_done) state_d = (credit != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        coin_rej_d = coin_nz;
        if (chg_valid && chg_ready) begin
          credit_d = credit - CREDIT_W'(1);
          if (credit == CREDIT_W'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      credit       <= '0;
      vend_id      <= '0;
      vend_req     <= 1'b0;
      chg_valid    <= 1'b0;
      busy         <= 1'b0;
      coin_rej     <= 1'b0;
      err_funds    <= 1'b0;
      err_sold_out <= 1'b0;
    end else begin
      state        <= state_d;
      credit       <= credit_d;
      vend_id      <= vend_id_d;
      vend_req     <= (state_d == S_VEND);
      chg_valid    <= (state_d == S_CHANGE);
      busy         <= (state_d != S_IDLE);
      coin_rej     <= coin_rej_d;
      err_funds    <= err_funds_d;
      err_sold_out <= err_sold_d;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Directed plus randomized bench for vend_controller against a behavioural model.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid, sel_valid, cancel, restock, vend_done, chg_ready;
  logic [2:0] coin_val;
  logic [1:0] sel;
  logic       vend_req, chg_valid, busy, coin_rej, err_funds, err_sold_out;
  logic [1:0] vend_id;
  logic [4:0] credit;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  localparam int M_IDLE = 0, M_VEND = 1, M_CHG = 2;
  int m_mode, m_credit, m_id;
  int m_stock [4];
  int m_price [4] = '{2, 3, 5, 7};
  bit e_rej, e_funds, e_sold;

  always #5 clk = ~clk;

  vend_controller #(
    .CREDIT_W   (5),
    .STOCK_W    (4),
    .INIT_STOCK (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_val     (coin_val),
    .sel_valid    (sel_valid),
    .sel          (sel),
    .cancel       (cancel),
    .restock      (restock),
    .vend_req     (vend_req),
    .vend_id      (vend_id),
    .vend_done    (vend_done),
    .chg_valid    (chg_valid),
    .chg_ready    (chg_ready),
    .credit       (credit),
    .busy         (busy),
    .coin_rej     (coin_rej),
    .err_funds    (err_funds),
    .err_sold_out (err_sold_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_credit = 0; m_id = 0;
    e_rej = 0; e_funds = 0; e_sold = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 3;
  endtask

  task automatic model_cycle();
    int add;
    bit coin;
    e_rej = 0; e_funds = 0; e_sold = 0;
    coin = coin_valid && (coin_val != 0);
    if (m_mode == M_IDLE) begin
      add = 0;
      if (coin) begin
        if (m_credit + int'(coin_val) <= 31) add = int'(coin_val);
        else e_rej = 1;
      end
      if (cancel) begin
        if (m_credit > 0) m_mode = M_CHG;
        m_credit += add;
      end else if (sel_valid) begin
        if (m_stock[sel] == 0) begin
          e_sold = 1; m_credit += add;
        end else if (m_credit < m_price[sel]) begin
          e_funds = 1; m_credit += add;
        end else begin
          m_stock[sel]--;
          m_credit = m_credit + add - m_price[sel];
          m_id = int'(sel);
          m_mode = M_VEND;
        end
      end else begin
        m_credit += add;
        if (restock) for (int i = 0; i < 4; i++) m_stock[i] = 3;
      end
    end else if (m_mode == M_VEND) begin
      e_rej = coin;
      if (vend_done) m_mode = (m_credit > 0) ? M_CHG : M_IDLE;
    end else begin
      e_rej = coin;
      if (chg_ready) begin
        m_credit--;
        if (m_credit == 0) m_mode = M_IDLE;
      end
    end
  endtask

  task automatic compare_all();
    chk("credit", 32'(credit), 32'(m_credit));
    chk("vend_req", 32'(vend_req), 32'(m_mode == M_VEND));
    chk("chg_valid", 32'(chg_valid), 32'(m_mode == M_CHG));
    chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
    chk("coin_rej", 32'(coin_rej), 32'(e_rej));
    chk("err_funds", 32'(err_funds), 32'(e_funds));
    chk("err_sold_out", 32'(err_sold_out), 32'(e_sold));
    if (m_mode == M_VEND) chk("vend_id", 32'(vend_id), 32'(m_id));
  endtask

  // One clock: drive on negedge, model at posedge, compare 1ns later
  task automatic step(input bit cvl, input int cv, input bit svl, input int s,
                      input bit cn, input bit rs, input bit vd, input bit rdy);
    @(negedge clk);
    coin_valid = cvl; coin_val = 3'(cv); sel_valid = svl; sel = 2'(s);
    cancel = cn; restock = rs; vend_done = vd; chg_ready = rdy;
    @(posedge clk);
    model_cycle();
    #1;
    compare_all();
  endtask

  task automatic coin(input int v);
    step(1, v, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pick(input int s);
    step(0, 0, 1, s, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic done();
    step(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (m_mode != M_IDLE && n < 40) begin
      step(0, 0, 0, 0, 0, 0, 1, 1);
      n++;
    end
    chk("drain_bound", 32'(m_mode), 32'(M_IDLE));
  endtask

  initial begin
    rst = 1'b0;
    coin_valid = 0; coin_val = 0; sel_valid = 0; sel = 0;
    cancel = 0; restock = 0; vend_done = 0; chg_ready = 0;
    model_reset();
    #3;
    chk("rst_credit", 32'(credit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vend_req", 32'(vend_req), 32'd0);
    chk("rst_chg_valid", 32'(chg_valid), 32'd0);
    #9 rst = 1'b1;
    idle();

    // Exact payment
    coin(2); coin(1); pick(1);
    chk("exact_credit", 32'(credit), 32'd0);
    idle(); done(); idle();

    // Change payout with alternating ready
    coin(7); pick(0); done();
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0, 0, 1'(~i & 1));
    chk("payout_end", 32'(credit), 32'd0);
    drain();

    // Insufficient funds, then refund
    coin(1); pick(3);
    chk("funds_credit", 32'(credit), 32'd1);
    idle();
    step(0, 0, 0, 0, 1, 0, 0, 0);
    drain();

    // Exhaust product 0
    for (int k = 0; k < 2; k++) begin
      coin(2); pick(0); done();
    end
    coin(2); pick(0);
    chk("soldout_pulse", 32'(err_sold_out), 32'd1);
    idle();
    step(0, 0, 0, 0, 1, 0, 0, 0);
    drain();
    step(0, 0, 0, 0, 0, 1, 0, 0);

    // Credit ceiling and coin during VEND
    for (int k = 0; k < 4; k++) coin(7);
    coin(7);
    chk("ovf_credit", 32'(credit), 32'd28);
    pick(3);
    coin(5);
    done();
    drain();

    // Simultaneous coin and selection
    coin(2);
    step(1, 3, 1, 0, 0, 0, 0, 0);
    chk("simul_credit", 32'(credit), 32'd3);
    done();
    drain();

    // Asynchronous reset mid-CHANGE
    coin(3); coin(3); pick(0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_chg_valid", 32'(chg_valid), 32'd0);
    chk("async_credit", 32'(credit), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 3, int'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 2, int'($urandom_range(0, 3)),
           $urandom_range(0, 39) < 2, $urandom_range(0, 39) < 1,
           $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
